// File: rtl/button_toggle_pkg.sv
// Shared types and constants for the push-button conditioning block.
package button_toggle_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        PRESS_CHECK   = 2'd1,
        PRESSED       = 2'd2,
        RELEASE_CHECK = 2'd3
    } btn_state_e;

endpackage

// File: rtl/button_toggle_pulser_sync2.sv
// Two-flop synchronizer that brings the raw asynchronous button into the clock domain.
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync_q1_q;
    logic sync_q1_d;
    logic sync_q2_q;
    logic sync_q2_d;

    always_comb begin
        sync_q1_d = d;
        sync_q2_d = sync_q1_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1_q <= 1'b0;
            sync_q2_q <= 1'b0;
        end else begin
            sync_q1_q <= sync_q1_d;
            sync_q2_q <= sync_q2_d;
        end
    end

    assign q = sync_q2_q;

endmodule

// File: rtl/button_toggle_pulser.sv
// Turns a bouncing push-button into one clean synchronous pulse per press plus a
// debounced level; the pulse is intended to drive a toggle flip-flop's T input.
module button_toggle_pulser
    import button_toggle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic pulse,
    output logic level
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic           btn_sync;
    btn_state_e     state_q;
    btn_state_e     state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic           pulse_q;
    logic           pulse_d;
    logic           level_q;
    logic           level_d;

    sync2 u_sync2 (
        .clock (clock),
        .reset (reset),
        .d     (button),
        .q     (btn_sync)
    );

    // Each CHECK state counts consecutive samples of the new level; any sample
    // of the old level sends the FSM straight back without touching the outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
        unique case (state_q)
            RELEASED: begin
                if (btn_sync) begin
                    state_d = PRESS_CHECK;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_CHECK: begin
                if (!btn_sync) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = RELEASE_CHECK;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_CHECK: begin
                if (btn_sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign pulse = pulse_q;
    assign level = level_q;

endmodule

// File: tb/tb_button_toggle_pulser.sv
// Bench for button_toggle_pulser with a window-based reference model and a
// downstream toggle flip-flop driven from pulse.
module tb_button_toggle_pulser;
    import button_toggle_pkg::*;

    localparam int D = 4;

    logic clock = 1'b0;
    logic reset;
    logic button;
    logic pulse;
    logic level;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    logic [1:0] exp_q[$];

    // Reference model: two-stage delay plus a window of the last D samples;
    // the debounced level flips when the whole window agrees on the other value.
    logic         m_s1;
    logic         m_s2;
    logic         m_level;
    logic [D-1:0] m_hist;

    logic tff_q;

    always #5 clock = ~clock;

    button_toggle_pulser #(.DEBOUNCE_CYCLES(D)) dut (
        .clock  (clock),
        .reset  (reset),
        .button (button),
        .pulse  (pulse),
        .level  (level)
    );

    always @(posedge clock) begin
        if (reset) tff_q <= 1'b0;
        else if (pulse) tff_q <= ~tff_q;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, predict, then compare after the rising edge.
    task automatic step(input logic b, input logic r);
        logic       mp;
        logic [1:0] e;
        button = b;
        reset  = r;
        mp     = 1'b0;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_hist = '0; m_level = 1'b0;
        end else begin
            m_hist = {m_hist[D-2:0], m_s2};
            if (!m_level && (&m_hist)) begin
                m_level = 1'b1;
                mp = 1'b1;
            end else if (m_level && !(|m_hist)) begin
                m_level = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
        exp_q.push_back({mp, m_level});
        @(posedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        check("pulse", 32'(pulse), 32'(e[1]));
        check("level", 32'(level), 32'(e[0]));
        if (pulse === 1'b1) pulse_cnt++;
    endtask

    task automatic hold(input logic b, input int n, output int p_idx, output int l_idx);
        logic prev;
        p_idx = 0;
        l_idx = 0;
        for (int i = 1; i <= n; i++) begin
            prev = level;
            step(b, 1'b0);
            if (pulse === 1'b1 && p_idx == 0) p_idx = i;
            if (level !== prev && l_idx == 0) l_idx = i;
        end
    endtask

    initial begin
        int p;
        int l;
        int found;
        int run;
        logic rb;
        reset  = 1'b1;
        button = 1'b0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_hist = '0; m_level = 1'b0;
        @(negedge clock);

        // Reset held with button high, then first press after reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("rst_state", 32'(dut.state_q), 32'(RELEASED));
        pulse_cnt = 0;
        hold(1'b1, 10, p, l);
        check("rst_pulse_idx", p, 6);
        check("rst_pulse_cnt", pulse_cnt, 1);

        // Clean press held 40 cycles
        hold(1'b0, 12, p, l);
        pulse_cnt = 0;
        hold(1'b1, 40, p, l);
        check("clean_pulse_idx", p, 6);
        check("clean_level_idx", l, 6);
        check("clean_pulse_cnt", pulse_cnt, 1);

        // Sustained release
        pulse_cnt = 0;
        hold(1'b0, 12, p, l);
        check("release_level_idx", l, 6);
        check("release_pulse_cnt", pulse_cnt, 0);

        // Bounce rejected
        pulse_cnt = 0;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        hold(1'b0, 10, p, l);
        check("bounce_pulse_cnt", pulse_cnt, 0);
        check("bounce_level", 32'(level), 0);

        // Bounce then settle high
        pulse_cnt = 0;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        hold(1'b1, 20, p, l);
        check("settle_pulse_idx", p, 6);
        check("settle_pulse_cnt", pulse_cnt, 1);

        // Short release glitch while pressed, then sustained drop
        pulse_cnt = 0;
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        hold(1'b1, 10, p, l);
        check("rel_glitch_level", 32'(level), 1);
        check("rel_glitch_pulse_cnt", pulse_cnt, 0);
        hold(1'b0, 12, p, l);
        check("rel_drop_level_idx", l, 6);
        check("rel_drop_pulse_cnt", pulse_cnt, 0);

        // Reset on the cycle pulse is high, button kept high
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1'b1, 1'b0);
            if (pulse === 1'b1) found = 1;
        end
        check("mid_pulse_seen", found, 1);
        step(1'b1, 1'b1);
        check("mid_state", 32'(dut.state_q), 32'(RELEASED));
        check("mid_pulse_low", 32'(pulse), 0);
        pulse_cnt = 0;
        hold(1'b1, 15, p, l);
        check("mid_repulse_idx", p, 6);
        check("mid_repulse_cnt", pulse_cnt, 1);

        // Toggle flip-flop driven from pulse: three presses
        step(1'b0, 1'b1);
        check("tff_init", 32'(tff_q), 0);
        hold(1'b1, 12, p, l); hold(1'b0, 12, p, l);
        check("tff_press1", 32'(tff_q), 1);
        hold(1'b1, 12, p, l); hold(1'b0, 12, p, l);
        check("tff_press2", 32'(tff_q), 0);
        hold(1'b1, 12, p, l); hold(1'b0, 12, p, l);
        check("tff_press3", 32'(tff_q), 1);

        // Random bouncing with occasional reset
        for (int i = 0; i < 80; i++) begin
            rb  = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 7);
            for (int j = 0; j < run; j++) step(rb, ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
